ring_move_scheduler: RTL and testbench

//  Sequences a modulo-N up/down ring-position FSM on behalf of two requesters.

---
 rtl/ring_move_scheduler_pkg.sv | 18 +
 rtl/ring_move_scheduler_if.sv | 27 ++
 rtl/ring_move_scheduler_rr_arbiter2.sv | 16 +
 rtl/ring_move_scheduler.sv | 116 +++++++++++
 tb/tb_ring_move_scheduler.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_move_scheduler_pkg.sv
// Shared types and helpers for the ring move scheduler: FSM state encoding and
// the shortest-direction decision used on every ring step.
package ring_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DONE = 2'd2
  } state_t;

  // Forward distance (target-pos) mod n; half-way ties resolve to +1.
  function automatic logic dir_up(input int pos, input int target, input int n);
    int d;
    d = (target - pos + n) % n;
    return (d <= n / 2);
  endfunction

endpackage

// File: rtl/ring_move_scheduler_if.sv
// Request/completion bundle between two client requesters and the scheduler.
// Slot 0 of each vector belongs to requester 0, slot 1 to requester 1.
interface ring_move_scheduler_if #(
  parameter int N_POS = 4
);
  localparam int PW = $clog2(N_POS);

  logic [1:0]      req_valid;
  logic [2*PW-1:0] req_target;
  logic [1:0]      req_ready;
  logic [1:0]      done;

  modport master (
    output req_valid,
    output req_target,
    input  req_ready,
    input  done
  );

  modport slave (
    input  req_valid,
    input  req_target,
    output req_ready,
    output done
  );

endinterface

// File: rtl/ring_move_scheduler_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester named by rr_ptr_i.
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       rr_ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = rr_ptr_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ring_move_scheduler.sv
// Ring move scheduler: accepts one target at a time from two requesters and walks
// the ring one position every STEP_DIV cycles along the shorter direction.
module ring_move_scheduler
  import ring_sched_pkg::*;
#(
  parameter  int N_POS    = 4,
  parameter  int STEP_DIV = 4,
  localparam int PW       = $clog2(N_POS)
) (
  input  logic                  clock,
  input  logic                  reset,
  ring_move_scheduler_if.slave  req_if,
  output logic                  step_en,
  output logic                  up,
  output logic [PW-1:0]         pos,
  output logic                  busy
);

  localparam int CW = $clog2(STEP_DIV + 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(STEP_DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [PW-1:0] target_q, target_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;

  logic [1:0]    grant;
  logic [PW-1:0] tgt_sel;
  logic          dir;
  logic          step_now;
  logic [PW-1:0] pos_step;

  rr_arbiter2 u_arb (
    .valid_i  (req_if.req_valid),
    .rr_ptr_i (rr_q),
    .grant_o  (grant)
  );

  assign tgt_sel  = grant[1] ? req_if.req_target[2*PW-1:PW] : req_if.req_target[PW-1:0];
  assign dir      = dir_up(int'(pos_q), int'(target_q), N_POS);
  assign step_now = (state_q == MOVE) && (cnt_q == '0);
  assign pos_step = dir ? (pos_q + PW'(1)) : (pos_q - PW'(1));

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          target_d = tgt_sel;
          owner_d  = grant[1];
          if (tgt_sel == pos_q) begin
            state_d = DONE;
          end else begin
            state_d = MOVE;
            cnt_d   = CNT_RELOAD;
          end
        end
      end
      MOVE: begin
        if (cnt_q == '0) begin
          pos_d = pos_step;
          if (pos_step == target_q) begin
            state_d = DONE;
          end else begin
            cnt_d = CNT_RELOAD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        // The requester just served yields priority on the next tie.
        rr_d    = ~owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q   <= '0;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  // Target and owner are only consumed after an accept, so they carry no reset.
  always_ff @(posedge clock) begin
    target_q <= target_d;
    owner_q  <= owner_d;
  end

  assign req_if.req_ready = ((state_q == IDLE) && !reset) ? grant : 2'b00;
  assign req_if.done      = (state_q == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign step_en          = step_now;
  assign up               = step_now & dir;
  assign pos              = pos_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_ring_move_scheduler.sv
// Testbench for ring_move_scheduler: table of moves scored against a queue of
// expected step/done events, plus hand sequences for STEP_DIV=1 and reset.
module tb_ring_move_scheduler;

  localparam int N  = 4;
  localparam int SD = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ring_move_scheduler_if #(.N_POS(N)) if4 ();
  ring_move_scheduler_if #(.N_POS(N)) if1 ();

  logic       step4, up4, busy4;
  logic [1:0] pos4;
  logic       step1, up1, busy1;
  logic [1:0] pos1;

  ring_move_scheduler #(.N_POS(N), .STEP_DIV(SD)) dut4 (
    .clock(clock), .reset(reset), .req_if(if4),
    .step_en(step4), .up(up4), .pos(pos4), .busy(busy4)
  );

  ring_move_scheduler #(.N_POS(N), .STEP_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .req_if(if1),
    .step_en(step1), .up(up1), .pos(pos1), .busy(busy1)
  );

  typedef struct {
    logic [1:0] v;
    logic [1:0] t0;
    logic [1:0] t1;
    logic [1:0] g;
    int         steps;
    logic [1:0] pos;
  } vec_t;

  typedef struct {
    int         cyc;
    bit         is_done;
    bit         up;
    logic [1:0] pos;
    logic [1:0] dv;
  } evt_t;

  evt_t exp_q[$];
  vec_t vecs[11];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   steps_seen = 0;
  int   mpos = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle; sample point is the falling edge. Scores dut4 events.
  task automatic tick();
    evt_t e;
    @(negedge clock);
    cyc++;
    if (mon_en && (step4 || if4.done != 2'b00)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", int'({step4, if4.done}), 0);
      end else begin
        e = exp_q.pop_front();
        chk("evt_cycle", cyc, e.cyc);
        chk("evt_kind", int'(if4.done != 2'b00), int'(e.is_done));
        if (e.is_done) begin
          chk("done_owner", int'(if4.done), int'(e.dv));
        end else begin
          chk("step_up", int'(up4), int'(e.up));
          chk("step_pos", int'(pos4), int'(e.pos));
          chk("step_busy", int'(busy4), 1);
          steps_seen++;
        end
      end
    end
  endtask

  // Expected events for a move accepted in cycle t toward g.
  task automatic model(input int t, input int g, input int owner);
    int   p, c, d;
    bit   u;
    evt_t e;
    p = mpos;
    c = t;
    while (p != g) begin
      c += SD;
      d = (g - p + N) % N;
      u = (d <= N / 2);
      e.cyc = c; e.is_done = 1'b0; e.up = u; e.pos = 2'(p); e.dv = 2'b00;
      exp_q.push_back(e);
      p = u ? (p + 1) % N : (p + N - 1) % N;
    end
    e.cyc = c + 1; e.is_done = 1'b1; e.up = 1'b0; e.pos = 2'(p);
    e.dv = (owner != 0) ? 2'b10 : 2'b01;
    exp_q.push_back(e);
    mpos = p;
  endtask

  task automatic run_vec(input vec_t v);
    int t, owner, g;
    if4.req_valid  = v.v;
    if4.req_target = {v.t1, v.t0};
    #1;
    for (int k = 0; k < 30 && if4.req_ready == 2'b00; k++) begin
      tick();
      #1;
    end
    chk("ready_seen", int'(if4.req_ready != 2'b00), 1);
    chk("grant", int'(if4.req_ready), int'(v.g));
    owner = int'(if4.req_ready[1]);
    g = (owner != 0) ? int'(v.t1) : int'(v.t0);
    t = cyc;
    steps_seen = 0;
    model(t, g, owner);
    tick();
    if (owner != 0) if4.req_target[3:2] = ~v.t1;
    else            if4.req_target[1:0] = ~v.t0;
    for (int k = 0; k < 40 && if4.done == 2'b00; k++) tick();
    chk("done_seen", int'(if4.done != 2'b00), 1);
    chk("final_pos", int'(pos4), int'(v.pos));
    chk("step_count", steps_seen, v.steps);
  endtask

  initial begin
    int dn;
    if4.req_valid  = 2'b11;
    if4.req_target = 4'b1110;
    if1.req_valid  = 2'b00;
    if1.req_target = 4'b0000;

    //          valid  t0     t1     grant  steps pos
    vecs[0]  = '{2'b11, 2'd2, 2'd3, 2'b01, 2, 2'd2};
    vecs[1]  = '{2'b11, 2'd0, 2'd3, 2'b10, 1, 2'd3};
    vecs[2]  = '{2'b01, 2'd1, 2'd0, 2'b01, 2, 2'd1};
    vecs[3]  = '{2'b01, 2'd1, 2'd0, 2'b01, 0, 2'd1};
    vecs[4]  = '{2'b10, 2'd0, 2'd3, 2'b10, 2, 2'd3};
    vecs[5]  = '{2'b01, 2'd0, 2'd0, 2'b01, 1, 2'd0};
    vecs[6]  = '{2'b10, 2'd0, 2'd3, 2'b10, 1, 2'd3};
    vecs[7]  = '{2'b01, 2'd2, 2'd0, 2'b01, 1, 2'd2};
    vecs[8]  = '{2'b11, 2'd3, 2'd0, 2'b10, 2, 2'd0};
    vecs[9]  = '{2'b11, 2'd0, 2'd1, 2'b01, 0, 2'd0};
    vecs[10] = '{2'b10, 2'd0, 2'd2, 2'b10, 2, 2'd2};

    tick();
    tick();
    #1;
    chk("rst_ready", int'(if4.req_ready), 0);
    chk("rst_busy", int'(busy4), 0);
    chk("rst_pos", int'(pos4), 0);
    chk("rst_step", int'(step4), 0);
    chk("rst_up", int'(up4), 0);
    chk("rst_done", int'(if4.done), 0);
    reset = 1'b0;
    if4.req_valid = 2'b00;
    tick();

    mon_en = 1'b1;
    for (int i = 0; i < 11; i++) run_vec(vecs[i]);
    if4.req_valid = 2'b00;
    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Zero-step move from pos 2: busy for exactly the DONE cycle.
    if4.req_valid  = 2'b01;
    if4.req_target = 4'b0010;
    #1;
    chk("zs_ready", int'(if4.req_ready), 1);
    chk("zs_busy_accept", int'(busy4), 0);
    tick();
    if4.req_valid = 2'b00;
    chk("zs_busy_done", int'(busy4), 1);
    chk("zs_done", int'(if4.done), 1);
    chk("zs_no_step", int'(step4), 0);
    tick();
    chk("zs_busy_after", int'(busy4), 0);
    chk("zs_done_after", int'(if4.done), 0);

    // STEP_DIV=1: 0->1, then tie 1->3 going up through 2.
    if1.req_valid  = 2'b01;
    if1.req_target = 4'b0001;
    #1;
    chk("sd1_ready_a", int'(if1.req_ready), 1);
    tick();
    if1.req_valid = 2'b00;
    chk("sd1_step_a", int'(step1 & up1), 1);
    chk("sd1_pos_a", int'(pos1), 0);
    tick();
    chk("sd1_done_a", int'(if1.done), 1);
    chk("sd1_pos_a2", int'(pos1), 1);
    if1.req_valid  = 2'b01;
    if1.req_target = 4'b0011;
    #1;
    chk("sd1_ready_in_done", int'(if1.req_ready), 0);
    tick();
    #1;
    chk("sd1_ready_b", int'(if1.req_ready), 1);
    tick();
    if1.req_valid = 2'b00;
    chk("sd1_step_b1", int'(step1 & up1), 1);
    chk("sd1_pos_b1", int'(pos1), 1);
    tick();
    chk("sd1_step_b2", int'(step1 & up1), 1);
    chk("sd1_pos_b2", int'(pos1), 2);
    tick();
    chk("sd1_done_b", int'(if1.done), 1);
    chk("sd1_pos_b3", int'(pos1), 3);
    chk("sd1_no_step", int'(step1), 0);
    tick();
    chk("sd1_idle", int'(busy1), 0);

    // Reset one cycle after the first step of a 2 -> 0 move.
    if4.req_valid  = 2'b01;
    if4.req_target = 4'b0000;
    #1;
    chk("rm_ready", int'(if4.req_ready), 1);
    for (int k = 0; k < 10 && !step4; k++) tick();
    chk("rm_step_seen", int'(step4 & up4), 1);
    tick();
    chk("rm_pos_after_step", int'(pos4), 3);
    reset = 1'b1;
    tick();
    #1;
    chk("rm_pos", int'(pos4), 0);
    chk("rm_busy", int'(busy4), 0);
    chk("rm_step", int'(step4), 0);
    chk("rm_done", int'(if4.done), 0);
    chk("rm_ready_in_reset", int'(if4.req_ready), 0);
    chk("rm_dut1_pos", int'(pos1), 0);
    reset = 1'b0;
    if4.req_valid = 2'b00;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (if4.done != 2'b00 || step4) dn++;
    end
    chk("rm_quiet_after_reset", dn, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
